// File: rtl/ddr_ctrl_arbit.sv
// ddr_ctrl_arbit: command arbiter for the SDRAM controller.
// It grants one request source at a time (priority AREF > WR > RD), routes the
// granted source's command, bank, address and data onto the SDRAM pins, and
// force-releases any grant whose source never signals end.
module ddr_ctrl_arbit #(
  parameter int ADDR_WIDTH  = 13,
  parameter int BA_WIDTH    = 2,
  parameter int DQ_WIDTH    = 16,
  parameter int TIMEOUT_MAX = 1023
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  init_end_i,
  input  logic [3:0]            init_cmd_i,
  input  logic [BA_WIDTH-1:0]   init_ba_i,
  input  logic [ADDR_WIDTH-1:0] init_addr_i,
  input  logic                  aref_req_i,
  input  logic                  aref_end_i,
  input  logic [3:0]            aref_cmd_i,
  input  logic [BA_WIDTH-1:0]   aref_ba_i,
  input  logic [ADDR_WIDTH-1:0] aref_addr_i,
  input  logic                  wr_req_i,
  input  logic                  wr_end_i,
  input  logic [3:0]            wr_cmd_i,
  input  logic [BA_WIDTH-1:0]   wr_ba_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                  wr_dq_oe_i,
  input  logic [DQ_WIDTH-1:0]   wr_dq_i,
  input  logic                  rd_req_i,
  input  logic                  rd_end_i,
  input  logic [3:0]            rd_cmd_i,
  input  logic [BA_WIDTH-1:0]   rd_ba_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  aref_en_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic                  sdram_cke_o,
  output logic                  sdram_cs_n_o,
  output logic                  sdram_ras_n_o,
  output logic                  sdram_cas_n_o,
  output logic                  sdram_we_n_o,
  output logic [BA_WIDTH-1:0]   sdram_ba_o,
  output logic [ADDR_WIDTH-1:0] sdram_addr_o,
  output logic                  sdram_dq_oe_o,
  output logic [DQ_WIDTH-1:0]   sdram_dq_o,
  output logic                  arb_err_o
);

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [9:0] TMAX    = 10'(TIMEOUT_MAX);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic [9:0] r_cnt;
  logic [9:0] w_cnt_next;
  logic       w_timeout;
  logic       w_granted;
  logic       w_own_end;
  logic       r_err;
  logic       r_aref_en;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_rst_done;

  logic [3:0]            w_cmd;
  logic [BA_WIDTH-1:0]   w_ba;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_dq_oe;
  logic [DQ_WIDTH-1:0]   w_dq;

  // Next-state decision: arbitration in IDLE, end/watchdog release in granted states.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = 10'd0;
    w_timeout    = 1'b0;
    w_granted    = 1'b0;
    w_own_end    = 1'b0;
    case (r_state)
      ARB_INIT: begin
        if (init_end_i) w_state_next = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (aref_req_i)    w_state_next = ARB_AREF;
        else if (wr_req_i) w_state_next = ARB_WRITE;
        else if (rd_req_i) w_state_next = ARB_READ;
      end
      ARB_AREF: begin
        w_granted = 1'b1;
        w_own_end = aref_end_i;
      end
      ARB_WRITE: begin
        w_granted = 1'b1;
        w_own_end = wr_end_i;
      end
      ARB_READ: begin
        w_granted = 1'b1;
        w_own_end = rd_end_i;
      end
      default: w_state_next = ARB_IDLE;
    endcase
    // A real end on the expiry cycle wins over the watchdog.
    if (w_granted) begin
      if (w_own_end) begin
        w_state_next = ARB_IDLE;
      end else if (r_cnt == TMAX) begin
        w_state_next = ARB_IDLE;
        w_timeout    = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 10'd1;
      end
    end
  end

  // State, watchdog, error pulse and registered (glitch-free) grant enables.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ARB_INIT;
      r_cnt      <= 10'd0;
      r_err      <= 1'b0;
      r_aref_en  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_err      <= w_timeout;
      r_aref_en  <= (w_state_next == ARB_AREF);
      r_wr_en    <= (w_state_next == ARB_WRITE);
      r_rd_en    <= (w_state_next == ARB_READ);
      r_rst_done <= 1'b1;
    end
  end

  // Pin mux from the registered state; pins idle at NOP until the first clock after reset.
  always_comb begin
    w_cmd   = CMD_NOP;
    w_ba    = '1;
    w_addr  = '1;
    w_dq_oe = 1'b0;
    w_dq    = '0;
    if (r_rst_done) begin
      case (r_state)
        ARB_INIT: begin
          w_cmd  = init_cmd_i;
          w_ba   = init_ba_i;
          w_addr = init_addr_i;
        end
        ARB_AREF: begin
          w_cmd  = aref_cmd_i;
          w_ba   = aref_ba_i;
          w_addr = aref_addr_i;
        end
        ARB_WRITE: begin
          w_cmd   = wr_cmd_i;
          w_ba    = wr_ba_i;
          w_addr  = wr_addr_i;
          w_dq_oe = wr_dq_oe_i;
          w_dq    = wr_dq_i;
        end
        ARB_READ: begin
          w_cmd  = rd_cmd_i;
          w_ba   = rd_ba_i;
          w_addr = rd_addr_i;
        end
        default: ;
      endcase
    end
  end

  assign aref_en_o     = r_aref_en;
  assign wr_en_o       = r_wr_en;
  assign rd_en_o       = r_rd_en;
  assign arb_err_o     = r_err;
  assign sdram_cke_o   = 1'b1;
  assign sdram_cs_n_o  = w_cmd[3];
  assign sdram_ras_n_o = w_cmd[2];
  assign sdram_cas_n_o = w_cmd[1];
  assign sdram_we_n_o  = w_cmd[0];
  assign sdram_ba_o    = w_ba;
  assign sdram_addr_o  = w_addr;
  assign sdram_dq_oe_o = w_dq_oe;
  assign sdram_dq_o    = w_dq;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// tb_ddr_ctrl_arbit: vector table, hand sequences and randomized traffic
// against a grant-owner/age reference model.
module tb_ddr_ctrl_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end_i = 1'b0;
  logic [3:0]  init_cmd_i = '0, aref_cmd_i = '0, wr_cmd_i = '0, rd_cmd_i = '0;
  logic [1:0]  init_ba_i = '0, aref_ba_i = '0, wr_ba_i = '0, rd_ba_i = '0;
  logic [12:0] init_addr_i = '0, aref_addr_i = '0, wr_addr_i = '0, rd_addr_i = '0;
  logic        aref_req_i = 1'b0, aref_end_i = 1'b0;
  logic        wr_req_i = 1'b0, wr_end_i = 1'b0, wr_dq_oe_i = 1'b0;
  logic [15:0] wr_dq_i = '0;
  logic        rd_req_i = 1'b0, rd_end_i = 1'b0;
  logic        aref_en_o, wr_en_o, rd_en_o, sdram_cke_o;
  logic        sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o;
  logic [1:0]  sdram_ba_o;
  logic [12:0] sdram_addr_o;
  logic        sdram_dq_oe_o;
  logic [15:0] sdram_dq_o;
  logic        arb_err_o;

  ddr_ctrl_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end_i(init_end_i),
    .init_cmd_i(init_cmd_i), .init_ba_i(init_ba_i), .init_addr_i(init_addr_i),
    .aref_req_i(aref_req_i), .aref_end_i(aref_end_i), .aref_cmd_i(aref_cmd_i),
    .aref_ba_i(aref_ba_i), .aref_addr_i(aref_addr_i),
    .wr_req_i(wr_req_i), .wr_end_i(wr_end_i), .wr_cmd_i(wr_cmd_i),
    .wr_ba_i(wr_ba_i), .wr_addr_i(wr_addr_i), .wr_dq_oe_i(wr_dq_oe_i), .wr_dq_i(wr_dq_i),
    .rd_req_i(rd_req_i), .rd_end_i(rd_end_i), .rd_cmd_i(rd_cmd_i),
    .rd_ba_i(rd_ba_i), .rd_addr_i(rd_addr_i),
    .aref_en_o(aref_en_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .sdram_cke_o(sdram_cke_o), .sdram_cs_n_o(sdram_cs_n_o), .sdram_ras_n_o(sdram_ras_n_o),
    .sdram_cas_n_o(sdram_cas_n_o), .sdram_we_n_o(sdram_we_n_o), .sdram_ba_o(sdram_ba_o),
    .sdram_addr_o(sdram_addr_o), .sdram_dq_oe_o(sdram_dq_oe_o), .sdram_dq_o(sdram_dq_o),
    .arb_err_o(arb_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // Reference model: who owns the bus (-1 init, 0 nobody, 1 refresh, 2 write, 3 read)
  // and how many cycles the current grant has been open.
  int m_owner = -1;
  int m_age   = 0;
  bit m_err   = 1'b0;
  bit m_done  = 1'b0;
  localparam int LIMIT = 1023;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_owner <= -1; m_age <= 0; m_err <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b1;
      m_err  <= 1'b0;
      if (m_owner == -1) begin
        if (init_end_i) m_owner <= 0;
      end else if (m_owner == 0) begin
        m_age <= 0;
        if (aref_req_i)    m_owner <= 1;
        else if (wr_req_i) m_owner <= 2;
        else if (rd_req_i) m_owner <= 3;
      end else begin
        if ((m_owner == 1 && aref_end_i) || (m_owner == 2 && wr_end_i) ||
            (m_owner == 3 && rd_end_i)) begin
          m_owner <= 0; m_age <= 0;
        end else if (m_age >= LIMIT) begin
          m_owner <= 0; m_age <= 0; m_err <= 1'b1;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [2:0]  ee;
    logic [18:0] ep;
    logic [16:0] ed;
    ee = {m_owner == 1, m_owner == 2, m_owner == 3};
    ep = {4'b0111, 2'b11, 13'h1fff};
    ed = '0;
    if (m_done) begin
      case (m_owner)
        -1: ep = {init_cmd_i, init_ba_i, init_addr_i};
        1:  ep = {aref_cmd_i, aref_ba_i, aref_addr_i};
        2:  begin ep = {wr_cmd_i, wr_ba_i, wr_addr_i}; ed = {wr_dq_oe_i, wr_dq_i}; end
        3:  ep = {rd_cmd_i, rd_ba_i, rd_addr_i};
        default: ;
      endcase
    end
    cmp("enables", 32'({aref_en_o, wr_en_o, rd_en_o}), 32'(ee));
    cmp("pins", 32'({sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
                     sdram_ba_o, sdram_addr_o}), 32'(ep));
    cmp("dq", 32'({sdram_dq_oe_o, sdram_dq_o}), 32'(ed));
    cmp("err", 32'(arb_err_o), 32'(m_err));
    cmp("cke", 32'(sdram_cke_o), 32'd1);
  endtask

  logic        tb_dq_oe = 1'b1;
  logic [15:0] tb_dq = 16'hA5A5;

  // One clock: drive at negedge, check 1 time unit after the rising edge.
  task automatic step(input logic [2:0] req, input logic [2:0] endp);
    @(negedge sys_clk);
    {aref_req_i, wr_req_i, rd_req_i} = req;
    {aref_end_i, wr_end_i, rd_end_i} = endp;
    init_cmd_i = 4'($urandom); init_ba_i = 2'($urandom); init_addr_i = 13'($urandom);
    aref_cmd_i = 4'b0010;      aref_ba_i = 2'($urandom); aref_addr_i = 13'($urandom);
    wr_cmd_i   = 4'($urandom); wr_ba_i   = 2'($urandom); wr_addr_i   = 13'($urandom);
    rd_cmd_i   = 4'($urandom); rd_ba_i   = 2'($urandom); rd_addr_i   = 13'($urandom);
    wr_dq_oe_i = tb_dq_oe; wr_dq_i = tb_dq;
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] endp;
    logic [2:0] exp_en;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];
  int n;

  initial begin
    // {aref,wr,rd} request | {aref,wr,rd} end | expected {aref,wr,rd} enable
    vecs[0]  = '{3'b111, 3'b000, 3'b100, 1'b0};
    vecs[1]  = '{3'b011, 3'b100, 3'b000, 1'b0};
    vecs[2]  = '{3'b011, 3'b000, 3'b010, 1'b0};
    vecs[3]  = '{3'b001, 3'b010, 3'b000, 1'b0};
    vecs[4]  = '{3'b001, 3'b000, 3'b001, 1'b0};
    vecs[5]  = '{3'b000, 3'b001, 3'b000, 1'b0};
    vecs[6]  = '{3'b010, 3'b000, 3'b010, 1'b0};
    vecs[7]  = '{3'b110, 3'b000, 3'b010, 1'b0};
    vecs[8]  = '{3'b100, 3'b010, 3'b000, 1'b0};
    vecs[9]  = '{3'b100, 3'b000, 3'b100, 1'b0};
    vecs[10] = '{3'b000, 3'b100, 3'b000, 1'b0};
    vecs[11] = '{3'b000, 3'b111, 3'b000, 1'b0};
    vecs[12] = '{3'b001, 3'b110, 3'b001, 1'b0};
    vecs[13] = '{3'b000, 3'b110, 3'b001, 1'b0};
    vecs[14] = '{3'b000, 3'b001, 3'b000, 1'b0};

    // Reset values while reset is held.
    #12;
    check_all();
    cmp("rst_en", 32'({aref_en_o, wr_en_o, rd_en_o}), 32'd0);
    cmp("rst_pins", 32'({sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
                         sdram_ba_o, sdram_addr_o}), 32'h3ffff);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Init phase: requests ignored, init fields on the pins.
    for (int i = 0; i < 20; i++) step(3'($urandom), 3'b000);
    cmp("init_pass", 32'(sdram_addr_o), 32'(init_addr_i));
    init_end_i = 1'b1;
    step(3'b000, 3'b000);
    cmp("idle_pins", 32'({sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o,
                          sdram_ba_o, sdram_addr_o}), 32'h3ffff);

    // Table: priority, IDLE gaps, no preemption of a write, stray ends.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].req, vecs[i].endp);
      cmp($sformatf("tbl%0d_en", i), 32'({aref_en_o, wr_en_o, rd_en_o}), 32'(vecs[i].exp_en));
      cmp($sformatf("tbl%0d_err", i), 32'(arb_err_o), 32'(vecs[i].exp_err));
      if (vecs[i].exp_en == 3'b100)
        cmp("aref_cmd", 32'({sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o}), 32'h2);
      if (vecs[i].exp_en == 3'b010)
        cmp("wr_dq", 32'({sdram_dq_oe_o, sdram_dq_o}), 32'h1A5A5);
    end

    // Watchdog expiry: grant held 1024 cycles, then drop with a 1-cycle error.
    step(3'b001, 3'b000);
    n = 1;
    for (int i = 0; i < 1100; i++) begin
      step(3'b000, 3'b000);
      if (rd_en_o) n++;
      else break;
    end
    cmp("wdog_len", 32'(n), 32'd1024);
    cmp("wdog_err", 32'(arb_err_o), 32'd1);
    step(3'b000, 3'b000);
    cmp("wdog_err_pulse", 32'(arb_err_o), 32'd0);

    // End arriving on the expiry cycle is a normal end.
    step(3'b001, 3'b000);
    for (int i = 0; i < 1023; i++) step(3'b000, 3'b000);
    cmp("edge_en_before", 32'(rd_en_o), 32'd1);
    step(3'b000, 3'b001);
    cmp("edge_en", 32'(rd_en_o), 32'd0);
    cmp("edge_err", 32'(arb_err_o), 32'd0);

    // Reset in the middle of a write grant.
    step(3'b010, 3'b000);
    cmp("pre_rst_wr", 32'({wr_en_o, sdram_dq_oe_o}), 32'h3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    cmp("midrst_en", 32'({aref_en_o, wr_en_o, rd_en_o}), 32'd0);
    cmp("midrst_oe", 32'(sdram_dq_oe_o), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    init_end_i = 1'b0;
    step(3'b111, 3'b000);
    cmp("post_rst_init", 32'({aref_en_o, wr_en_o, rd_en_o}), 32'd0);
    init_end_i = 1'b1;
    step(3'b000, 3'b000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tb_dq_oe = 1'($urandom);
      tb_dq = 16'($urandom);
      step(3'($urandom), {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
